wb_sevenseg_scroller: RTL and testbench
=======================================

# wb_sevenseg_scroller

Wishbone-controlled scroll sequencer for the 8-digit seven-segment peripheral. The CPU pushes a hex message of up to DEPTH nibbles through a slave port. The block then acts as a Wishbone master and periodically rewrites the display's 32-bit word register with an 8-nibble window that advances by one digit per period. It sits between the CPU interconnect (slave side) and the seven-segment slave (master side), so the CPU is relieved of display timing.

## Interface
- DEPTH, 16: message buffer depth in nibbles; power of two, 8..256.
- SEG_ADDR, 32'h0: address driven on o_wbm_adr for every display write.
- PAD, 4'h0: nibble shown in unused digits when the message is shorter than 8.
- i_wb_clk  in  1  clock; the block uses only this clock.
- i_wb_rst_n  in  1  reset, asynchronous, active-low.
- i_wb_adr  in  4  slave address; [3:2] selects the register.
- i_wb_dat  in  32  slave write data.
- i_wb_sel  in  4  slave byte select; ignored, all writes are full-word.
- i_wb_we, i_wb_cyc, i_wb_stb  in  1  slave control.
- o_wb_rdt  out  32  slave read data, registered.
- o_wb_ack  out  1  slave ack.
- o_wbm_adr  out  32  master address, constant SEG_ADDR.
- o_wbm_dat  out  32  master write data, the assembled window.
- o_wbm_sel  out  4  constant 4'hF.
- o_wbm_we, o_wbm_cyc, o_wbm_stb  out  1  master control; we equals cyc.
- i_wbm_ack  in  1  master ack.

## Operation
- Slave registers (offset = adr[3:2]):
  - 0 CTRL: bit0 EN (R/W); bit1 CLR (write-1 pulse, reads 0); bit2 OVFCLR (write-1 pulse, reads 0).
  - 1 DIV: R/W, 32 bits. Scroll period in cycles. A value of 0 behaves as 1.
  - 2 PUSH: write-only. Appends i_wb_dat[3:0] at the tail. A push when full is dropped and sets OVF. Reads return 0.
  - 3 STATUS: read-only. [8:0] COUNT, [9] BUSY (state != IDLE), [10] FULL, [11] OVF (sticky).
- Slave ack: o_wb_ack <= cyc & stb & !o_wb_ack. A write takes effect on the cycle the ack is raised. o_wb_rdt is valid with the ack.
- Buffer: circular, holding COUNT nibbles from the head. START is a window offset in 0..COUNT-1.
- Window assembly: digit k (o_wbm_dat[31-4k -: 4], k=0 leftmost) is loaded as follows.
  - COUNT>=8: buf[(START+k) mod COUNT].
  - COUNT<8: buf[k] for k<COUNT, PAD otherwise.
- FSM states IDLE, LOAD, WRITE, WAIT.
  - IDLE -> LOAD when EN=1 and COUNT>0.
  - LOAD: 8 cycles, one digit per cycle, index k=0..7, shifted into the word register. Go to IDLE at the next edge if EN=0, CLR occurs, or COUNT=0. Otherwise go to WRITE after k=7.
  - WRITE: cyc=stb=1, dat stable, until i_wbm_ack. On ack, drop cyc/stb the same edge. Then:
    - if COUNT>=8, START <= (START+1) mod COUNT;
    - load the timer with DIV-1;
    - go to WAIT.
    - WRITE is never abandoned: EN=0 or CLR during WRITE takes effect after the ack.
  - WAIT: timer decrements each cycle. At 0 go to LOAD. Go to IDLE at the next edge if EN=0, CLR occurs, or COUNT=0.
- CLR: sets head, COUNT, START and OVF to 0. It does not change EN or DIV. CLR and PUSH cannot coincide (distinct registers).
- A push during scrolling increments COUNT immediately. The next LOAD uses the new COUNT.
- If START >= COUNT at LOAD entry (only possible after CLR and refill), START is forced to 0.
- Reset values:
  - o_wb_ack=0, o_wb_rdt=0.
  - o_wbm_cyc=o_wbm_stb=o_wbm_we=0, o_wbm_dat=0.
  - EN=0, DIV=0, COUNT=0, START=0, OVF=0, state IDLE.
  - Reset asserted mid-WRITE drops cyc/stb immediately (asynchronous).

## Timing
- Enable to first strobe: the EN write is acked at edge T. LOAD runs T+1..T+8. stb rises at T+9.
- Period between successive strobe rises = ack latency L (cycles stb high) + max(DIV,1) + 8.
- No combinational path from slave inputs to any output; all outputs are registered.

## Structure
- Shared package/include wb_sevenseg_pkg: state encodings, register offsets (CTRL/DIV/PUSH/STATUS), STATUS bit positions.
- Sub-module sevenseg_msgbuf: nibble array with head/count and a push/clear/full/overflow interface. It exposes one read port addressed by absolute index.
- The top level holds the slave register file, the FSM, the timer and the window assembly.

## Test plan
- Push 1..A (10 nibbles), DIV=4, EN=1, slave acking in 1 cycle:
  - writes are 0x12345678, then 0x23456789, 0x3456789A, 0x456789A1, …;
  - strobes are 13 cycles apart.
- Push 3 nibbles A,B,C with PAD=0:
  - every write is 0xABC00000;
  - START stays 0 and STATUS.COUNT=3.
- Fill 16, push a 17th:
  - FULL=1, OVF=1, COUNT=16, no data change;
  - OVFCLR clears OVF only.
- EN=0 and CLR written while WRITE is stalled (ack delayed 20 cycles):
  - stb is held until the ack, then IDLE;
  - no further strobes; COUNT=0.
- Reset asserted mid-WAIT and mid-WRITE:
  - all outputs go to 0 asynchronously;
  - after release, STATUS=0 and no strobe until re-enabled.
- DIV=0 versus DIV=1: identical strobe spacing (L+9).

Source files
------------

// File: rtl/wb_sevenseg_scroller_pkg.sv
// Shared constants for the seven-segment scroll sequencer: FSM encodings,
// slave register offsets and CTRL/STATUS bit positions.
package wb_sevenseg_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DIV    = 2'd1;
   localparam logic [1:0] REG_PUSH   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_CLR    = 1;
   localparam int unsigned CTRL_OVFCLR = 2;

   localparam int unsigned STAT_BUSY = 9;
   localparam int unsigned STAT_FULL = 10;
   localparam int unsigned STAT_OVF  = 11;

   // A period of 0 behaves as 1, so both reload the timer with 0.
   function automatic logic [31:0] timer_reload(input logic [31:0] div);
      return (div == '0) ? '0 : div - 32'd1;
   endfunction

endpackage

// File: rtl/wb_sevenseg_scroller_if.sv
// Classic Wishbone bus bundle; AW sizes the address for slave or master use.
interface wb_sevenseg_scroller_if #(
   parameter int unsigned AW = 32
) ();
   logic [AW-1:0] adr;
   logic [31:0]   dat;
   logic [3:0]    sel;
   logic          we;
   logic          cyc;
   logic          stb;
   logic [31:0]   rdt;
   logic          ack;

   modport master (output adr, dat, sel, we, cyc, stb, input ack);
   modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
endinterface

// File: rtl/wb_sevenseg_scroller_msgbuf.sv
// Circular nibble buffer: push at the tail, clear, full/sticky overflow and
// one combinational read port addressed by absolute index.
module sevenseg_msgbuf #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned IW    = $clog2(DEPTH),
   localparam int unsigned CW    = IW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [3:0]    push_data,
   input  logic          clr,
   input  logic          ovf_clr,
   input  logic [IW-1:0] rd_idx,
   output logic [3:0]    rd_data,
   output logic [IW-1:0] head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          ovf
);

   logic [3:0]    mem [DEPTH];
   logic [IW-1:0] tail;

   assign tail    = head + count[IW-1:0];
   assign full    = (count == CW'(DEPTH));
   assign rd_data = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         head  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (ovf_clr)
            ovf <= 1'b0;
         if (push) begin
            if (full)
               ovf <= 1'b1;
            else
               count <= count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !clr)
         mem[tail] <= push_data;
   end

endmodule

// File: rtl/wb_sevenseg_scroller.sv
// Wishbone scroll sequencer: CPU-facing register slave plus a master that
// periodically rewrites the display with an 8-digit window of the message.
module wb_sevenseg_scroller
   import wb_sevenseg_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter logic [31:0] SEG_ADDR = 32'h0,
   parameter logic [3:0]  PAD      = 4'h0
) (
   input  logic i_wb_clk,
   input  logic i_wb_rst_n,
   wb_sevenseg_scroller_if.slave  wbs,
   wb_sevenseg_scroller_if.master wbm
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   logic [1:0]    state;
   logic          en;
   logic [31:0]   div;
   logic [31:0]   timer;
   logic [2:0]    k;
   logic [IW-1:0] start;
   logic [31:0]   word;
   logic          m_cyc;
   logic          ack_q;
   logic [31:0]   rdt_q;

   logic          acc, wr_fire, clr_p, ovfclr_p, push_p;
   logic [1:0]    reg_sel;
   logic [IW-1:0] head, rd_idx, rel;
   logic [CW-1:0] count, sum_w;
   logic          full, ovf, long_msg, use_pad;
   logic [3:0]    rd_data, digit;
   logic [31:0]   status, rd_val;

   assign acc      = wbs.cyc & wbs.stb & ~ack_q;
   assign wr_fire  = acc & wbs.we;
   assign reg_sel  = wbs.adr[3:2];
   assign clr_p    = wr_fire && (reg_sel == REG_CTRL) && wbs.dat[CTRL_CLR];
   assign ovfclr_p = wr_fire && (reg_sel == REG_CTRL) && wbs.dat[CTRL_OVFCLR];
   assign push_p   = wr_fire && (reg_sel == REG_PUSH);

   sevenseg_msgbuf #(.DEPTH(DEPTH)) u_buf (
      .clk       (i_wb_clk),
      .rst_n     (i_wb_rst_n),
      .push      (push_p),
      .push_data (wbs.dat[3:0]),
      .clr       (clr_p),
      .ovf_clr   (ovfclr_p),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .head      (head),
      .count     (count),
      .full      (full),
      .ovf       (ovf)
   );

   // (START+k) mod COUNT without a divider: START<COUNT and k<8<=COUNT, so one
   // conditional subtract suffices; working mod DEPTH keeps COUNT=DEPTH exact.
   always_comb begin
      long_msg = (count >= CW'(8));
      sum_w    = CW'(start) + CW'(k);
      if (long_msg)
         rel = start + IW'(k) - ((sum_w >= count) ? count[IW-1:0] : '0);
      else
         rel = IW'(k);
      use_pad = !long_msg && (CW'(k) >= count);
      rd_idx  = head + rel;
      digit   = use_pad ? PAD : rd_data;
   end

   always_comb begin
      status                = '0;
      status[CW-1:0]        = count;
      status[STAT_BUSY]     = (state != ST_IDLE);
      status[STAT_FULL]     = full;
      status[STAT_OVF]      = ovf;
      rd_val = '0;
      case (reg_sel)
         REG_CTRL: rd_val[CTRL_EN] = en;
         REG_DIV:  rd_val = div;
         REG_PUSH: rd_val = '0;
         default:  rd_val = status;
      endcase
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         state <= ST_IDLE;
         en    <= 1'b0;
         div   <= '0;
         timer <= '0;
         k     <= '0;
         start <= '0;
         word  <= '0;
         m_cyc <= 1'b0;
         ack_q <= 1'b0;
         rdt_q <= '0;
      end else begin
         ack_q <= acc;
         if (acc && !wbs.we)
            rdt_q <= rd_val;
         if (wr_fire && reg_sel == REG_CTRL)
            en <= wbs.dat[CTRL_EN];
         if (wr_fire && reg_sel == REG_DIV)
            div <= wbs.dat;

         case (state)
            ST_IDLE: begin
               k <= '0;
               if (en && count != '0) begin
                  state <= ST_LOAD;
                  if (CW'(start) >= count)
                     start <= '0;
               end
            end
            ST_LOAD: begin
               if (!en || clr_p || count == '0) begin
                  state <= ST_IDLE;
               end else begin
                  word <= {word[27:0], digit};
                  k    <= k + 3'd1;
                  if (k == 3'd7) begin
                     state <= ST_WRITE;
                     m_cyc <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (wbm.ack) begin
                  m_cyc <= 1'b0;
                  if (long_msg)
                     start <= (CW'(start) + CW'(1) == count) ? '0 : start + IW'(1);
                  timer <= timer_reload(div);
                  state <= ST_WAIT;
               end
            end
            default: begin
               if (!en || clr_p || count == '0) begin
                  state <= ST_IDLE;
               end else if (timer == '0) begin
                  state <= ST_LOAD;
                  k     <= '0;
                  if (CW'(start) >= count)
                     start <= '0;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
         endcase

         if (clr_p)
            start <= '0;
      end
   end

   assign wbs.ack = ack_q;
   assign wbs.rdt = rdt_q;
   assign wbm.adr = SEG_ADDR;
   assign wbm.dat = word;
   assign wbm.sel = 4'hF;
   assign wbm.we  = m_cyc;
   assign wbm.cyc = m_cyc;
   assign wbm.stb = m_cyc;

endmodule

// File: tb/tb_wb_sevenseg_scroller.sv
// Randomized bench for wb_sevenseg_scroller with a queue-based message model.
module tb_wb_sevenseg_scroller;

   localparam int unsigned DEPTH    = 16;
   localparam logic [31:0] SEG_ADDR = 32'hA000_0010;
   localparam logic [3:0]  PAD      = 4'h0;
   localparam logic [1:0]  R_CTRL = 2'd0, R_DIV = 2'd1, R_PUSH = 2'd2, R_STATUS = 2'd3;

   typedef struct {
      int unsigned cyc;
      logic [31:0] dat;
      logic [31:0] dat_ack;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        we;
   } strobe_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   int unsigned errors = 0, checks = 0;
   int unsigned lat = 1, hold = 0;
   logic ack_r = 1'b0, prev_stb = 1'b0;
   strobe_t slog[$];
   logic [3:0] msg[$];

   wb_sevenseg_scroller_if #(.AW(4))  wbs ();
   wb_sevenseg_scroller_if #(.AW(32)) wbm ();
   assign wbm.ack = ack_r;
   assign wbm.rdt = '0;

   wb_sevenseg_scroller #(.DEPTH(DEPTH), .SEG_ADDR(SEG_ADDR), .PAD(PAD)) dut (
      .i_wb_clk   (clk),
      .i_wb_rst_n (rst_n),
      .wbs        (wbs),
      .wbm        (wbm)
   );

   // Display-side slave: logs each strobe rise, acks after lat cycles of stb.
   always begin
      @(posedge clk);
      #1;
      if (wbm.stb && !prev_stb) begin
         strobe_t s;
         s.cyc = cyc_n; s.dat = wbm.dat; s.dat_ack = wbm.dat;
         s.adr = wbm.adr; s.sel = wbm.sel; s.we = wbm.we;
         slog.push_back(s);
      end
      prev_stb = wbm.stb;
      if (ack_r) begin
         ack_r = 1'b0;
      end else if (wbm.stb) begin
         hold++;
         if (hold >= lat) begin
            ack_r = 1'b1;
            hold = 0;
            if (slog.size() > 0) slog[slog.size()-1].dat_ack = wbm.dat;
         end
      end else begin
         hold = 0;
      end
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] model_window(input int unsigned start);
      int unsigned n = msg.size();
      logic [31:0] w = '0;
      for (int unsigned kk = 0; kk < 8; kk++) begin
         logic [3:0] nib;
         if (n >= 8)      nib = msg[(start + kk) % n];
         else if (kk < n) nib = msg[kk];
         else             nib = PAD;
         w = {w[27:0], nib};
      end
      return w;
   endfunction

   task automatic wb_xfer(input logic [1:0] r, input logic we, input logic [31:0] d,
                          output logic [31:0] rd, output int unsigned t_ack);
      bit got = 1'b0;
      @(negedge clk);
      wbs.adr = {r, 2'b00}; wbs.dat = d; wbs.we = we; wbs.sel = 4'hF;
      wbs.cyc = 1'b1; wbs.stb = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk);
         #1;
         got = wbs.ack;
      end
      rd = wbs.rdt; t_ack = cyc_n;
      wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bus_ack: reg %0d ack=0, required ack=1 within 8 cycles", r);
      end
   endtask

   task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
      logic [31:0] rd; int unsigned t;
      wb_xfer(r, 1'b1, d, rd, t);
   endtask

   task automatic wb_write_t(input logic [1:0] r, input logic [31:0] d, output int unsigned t);
      logic [31:0] rd;
      wb_xfer(r, 1'b1, d, rd, t);
   endtask

   task automatic wb_read(input logic [1:0] r, output logic [31:0] rd);
      int unsigned t;
      wb_xfer(r, 1'b0, 32'h0, rd, t);
   endtask

   task automatic push_nib(input logic [3:0] n);
      logic [31:0] d = $urandom();
      d[3:0] = n;
      wb_write(R_PUSH, d);
      if (msg.size() < DEPTH) msg.push_back(n);
   endtask

   task automatic start_scroll(input int unsigned d, input int unsigned l, output int unsigned t_en);
      lat = l;
      wb_write(R_DIV, d);
      wb_write_t(R_CTRL, 32'h1, t_en);
   endtask

   task automatic stop_and_clear();
      wb_write(R_CTRL, 32'h2);
      repeat (30) @(posedge clk);
      #2;
      slog.delete();
      msg.delete();
   endtask

   task automatic wait_strobes(input string tag, input int unsigned n, input int unsigned budget);
      for (int i = 0; i < budget && slog.size() < n; i++) begin
         @(posedge clk);
         #2;
      end
      checks++;
      if (slog.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: strobes=%0d, required %0d", tag, slog.size(), n);
      end
   endtask

   task automatic check_run(input string tag, input int unsigned nstr, input int unsigned t_en,
                            input int unsigned per);
      int unsigned start = 0;
      logic [31:0] exp;
      wait_strobes(tag, nstr, nstr * (per + 4) + 40);
      if (slog.size() > 0) begin
         checks++;
         if (slog[0].cyc !== t_en + 9) begin
            errors++;
            $display("FAIL %s_first_strobe: cycle %0d, required %0d", tag, slog[0].cyc, t_en + 9);
         end
         checks++;
         if (slog[0].adr !== SEG_ADDR || slog[0].sel !== 4'hF || slog[0].we !== 1'b1) begin
            errors++;
            $display("FAIL %s_master_ctl: adr=%h sel=%h we=%b, required adr=%h sel=f we=1",
                     tag, slog[0].adr, slog[0].sel, slog[0].we, SEG_ADDR);
         end
      end
      for (int unsigned i = 0; i < nstr && i < slog.size(); i++) begin
         exp = model_window(start);
         checks++;
         if (slog[i].dat !== exp) begin
            errors++;
            $display("FAIL %s_data[%0d]: got %h, required %h", tag, i, slog[i].dat, exp);
         end
         checks++;
         if (slog[i].dat_ack !== exp) begin
            errors++;
            $display("FAIL %s_data_at_ack[%0d]: got %h, required %h", tag, i, slog[i].dat_ack, exp);
         end
         if (i > 0) begin
            checks++;
            if (slog[i].cyc - slog[i-1].cyc !== per) begin
               errors++;
               $display("FAIL %s_spacing[%0d]: got %0d, required %0d", tag, i,
                        slog[i].cyc - slog[i-1].cyc, per);
            end
         end
         if (msg.size() >= 8) start = (start + 1) % msg.size();
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (wbs.ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b, required 0", wbs.ack); end
      checks++; if (wbs.rdt !== 32'h0) begin errors++; $display("FAIL rst_rdt: got %h, required 0", wbs.rdt); end
      checks++; if (wbm.cyc !== 1'b0 || wbm.stb !== 1'b0 || wbm.we !== 1'b0) begin
         errors++; $display("FAIL rst_master_ctl: cyc=%b stb=%b we=%b, required 0", wbm.cyc, wbm.stb, wbm.we);
      end
      checks++; if (wbm.dat !== 32'h0) begin errors++; $display("FAIL rst_wbm_dat: got %h, required 0", wbm.dat); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      wb_read(R_STATUS, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_status: got %h, required 0", rd); end
      wb_read(R_CTRL, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h, required 0", rd); end
      wb_read(R_DIV, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_div: got %h, required 0", rd); end
      repeat (20) @(posedge clk);
      #2;
      checks++; if (slog.size() !== 0) begin errors++; $display("FAIL rst_no_strobe: strobes=%0d, required 0", slog.size()); end
   endtask

   task automatic test_scroll_basic();
      logic [31:0] tab [4] = '{32'h12345678, 32'h23456789, 32'h3456789A, 32'h456789A1};
      logic [31:0] rd;
      int unsigned t;
      for (int unsigned i = 1; i <= 10; i++) push_nib(4'(i));
      wb_write(R_DIV, 32'd4);
      wb_read(R_DIV, rd);
      checks++; if (rd !== 32'd4) begin errors++; $display("FAIL div_readback: got %h, required 4", rd); end
      start_scroll(4, 1, t);
      check_run("basic", 6, t, 13);
      for (int unsigned i = 0; i < 4 && i < slog.size(); i++) begin
         checks++;
         if (slog[i].dat !== tab[i]) begin
            errors++; $display("FAIL basic_table[%0d]: got %h, required %h", i, slog[i].dat, tab[i]);
         end
      end
      stop_and_clear();
   endtask

   task automatic test_short_pad();
      logic [31:0] rd;
      int unsigned t;
      push_nib(4'hA); push_nib(4'hB); push_nib(4'hC);
      start_scroll(2, 1, t);
      check_run("short", 3, t, 11);
      for (int unsigned i = 0; i < 3 && i < slog.size(); i++) begin
         checks++;
         if (slog[i].dat !== 32'hABC00000) begin
            errors++; $display("FAIL short_pad[%0d]: got %h, required abc00000", i, slog[i].dat);
         end
      end
      wb_read(R_STATUS, rd);
      checks++; if (rd[8:0] !== 9'd3) begin errors++; $display("FAIL short_count: got %0d, required 3", rd[8:0]); end
      stop_and_clear();
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      int unsigned t;
      for (int i = 0; i < 16; i++) push_nib(4'($urandom_range(0, 15)));
      wb_read(R_STATUS, rd);
      checks++; if (rd !== 32'h0000_0410) begin errors++; $display("FAIL ovf_full16: status %h, required 00000410", rd); end
      push_nib(4'($urandom_range(0, 15)));
      wb_read(R_STATUS, rd);
      checks++; if (rd !== 32'h0000_0C10) begin errors++; $display("FAIL ovf_set: status %h, required 00000c10", rd); end
      wb_write(R_CTRL, 32'h4);
      wb_read(R_STATUS, rd);
      checks++; if (rd !== 32'h0000_0410) begin errors++; $display("FAIL ovf_clear: status %h, required 00000410", rd); end
      wb_read(R_CTRL, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_pulses_read0: got %h, required 0", rd); end
      start_scroll(1, 1, t);
      check_run("ovf", 3, t, 10);
      stop_and_clear();
   endtask

   task automatic test_stall_clear();
      logic [31:0] rd;
      int unsigned t, r, fall = 0;
      bit fell = 1'b0;
      for (int i = 0; i < 10; i++) push_nib(4'($urandom_range(0, 15)));
      start_scroll(3, 20, t);
      wait_strobes("stall", 1, 40);
      r = (slog.size() > 0) ? slog[0].cyc : 0;
      repeat (3) @(posedge clk);
      wb_write(R_CTRL, 32'h2);
      checks++; if (wbm.stb !== 1'b1) begin errors++; $display("FAIL stall_stb_held: stb=%b, required 1", wbm.stb); end
      for (int i = 0; i < 40 && !fell; i++) begin
         @(posedge clk);
         #2;
         if (!wbm.stb) begin fell = 1'b1; fall = cyc_n; end
      end
      checks++; if (!fell || fall - r !== 20) begin
         errors++; $display("FAIL stall_stb_len: got %0d cycles (fell=%b), required 20", fall - r, fell);
      end
      if (slog.size() > 0) begin
         checks++;
         if (slog[0].dat_ack !== model_window(0)) begin
            errors++; $display("FAIL stall_data: got %h, required %h", slog[0].dat_ack, model_window(0));
         end
      end
      repeat (40) @(posedge clk);
      #2;
      checks++; if (slog.size() !== 1) begin errors++; $display("FAIL stall_no_more: strobes=%0d, required 1", slog.size()); end
      wb_read(R_STATUS, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL stall_status: got %h, required 0", rd); end
      slog.delete();
      msg.delete();
   endtask

   task automatic test_random_scroll();
      int unsigned n, d, l, t;
      for (int it = 0; it < 5; it++) begin
         n = $urandom_range(1, 16);
         d = $urandom_range(0, 6);
         l = $urandom_range(1, 3);
         for (int unsigned i = 0; i < n; i++) push_nib(4'($urandom_range(0, 15)));
         start_scroll(d, l, t);
         check_run("rand", 5, t, l + ((d == 0) ? 1 : d) + 8);
         stop_and_clear();
      end
   endtask

   task automatic test_div0_vs_div1();
      int unsigned t;
      int unsigned sp [2] = '{0, 0};
      for (int unsigned d = 0; d < 2; d++) begin
         for (int i = 0; i < 9; i++) push_nib(4'($urandom_range(0, 15)));
         start_scroll(d, 2, t);
         check_run("div01", 4, t, 11);
         if (slog.size() >= 2) sp[d] = slog[1].cyc - slog[0].cyc;
         stop_and_clear();
      end
      checks++; if (sp[0] !== sp[1]) begin
         errors++; $display("FAIL div0_eq_div1: div0 spacing %0d, div1 spacing %0d, required equal", sp[0], sp[1]);
      end
   endtask

   task automatic reset_mid(input string tag, input int unsigned d, input int unsigned l, input logic exp_stb);
      logic [31:0] rd;
      int unsigned t;
      for (int i = 0; i < 10; i++) push_nib(4'($urandom_range(0, 15)));
      start_scroll(d, l, t);
      wait_strobes(tag, 1, 40);
      wb_read(R_STATUS, rd);
      repeat (5) @(posedge clk);
      #1;
      checks++; if (wbm.stb !== exp_stb) begin errors++; $display("FAIL %s_pre_state: stb=%b, required %b", tag, wbm.stb, exp_stb); end
      checks++; if (wbs.rdt === 32'h0) begin errors++; $display("FAIL %s_pre_rdt: rdt=%h, required nonzero", tag, wbs.rdt); end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (wbm.cyc !== 1'b0 || wbm.stb !== 1'b0 || wbm.we !== 1'b0) begin
         errors++; $display("FAIL %s_async_ctl: cyc=%b stb=%b we=%b, required 0", tag, wbm.cyc, wbm.stb, wbm.we);
      end
      checks++; if (wbm.dat !== 32'h0 || wbs.rdt !== 32'h0 || wbs.ack !== 1'b0) begin
         errors++; $display("FAIL %s_async_data: dat=%h rdt=%h ack=%b, required 0", tag, wbm.dat, wbs.rdt, wbs.ack);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      msg.delete();
      repeat (30) @(posedge clk);
      #2;
      checks++; if (slog.size() !== 1) begin errors++; $display("FAIL %s_no_strobe: strobes=%0d, required 1", tag, slog.size()); end
      wb_read(R_STATUS, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s_status: got %h, required 0", tag, rd); end
      wb_read(R_CTRL, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s_ctrl: got %h, required 0", tag, rd); end
      slog.delete();
   endtask

   task automatic test_async_reset();
      reset_mid("rst_wait", 20, 1, 1'b0);
      reset_mid("rst_write", 2, 20, 1'b1);
   endtask

   initial begin
      wbs.adr = '0; wbs.dat = '0; wbs.sel = '0;
      wbs.we = 1'b0; wbs.cyc = 1'b0; wbs.stb = 1'b0;
      test_reset();
      test_scroll_basic();
      test_short_pad();
      test_overflow();
      test_stall_clear();
      test_random_scroll();
      test_div0_vs_div1();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
